bullet_controller: RTL and testbench

BULLET_CONTROLLER -- requirements
Module: bullet_controller

---
 rtl/bullet_controller.sv | 178 +++++++++++++++++
 tb/tb_bullet_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_controller.sv
// Single-bullet controller: spawn at tank centre, fly per frame, retire, cool down.
// Optional wall ricochet enabled by defining BULLET_BOUNCE_EN.
module bullet_controller #(
  parameter logic [9:0] BULLET_STEP = 10'd4,
  parameter logic [7:0] BULLET_LIFE = 8'd120,
  parameter logic [7:0] COOLDOWN    = 8'd15,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MAX       = 10'd479
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] X_Tank,
  input  logic [9:0] Y_Tank,
  input  logic [9:0] Tank_Width,
  input  logic [9:0] Tank_Height,
  input  logic [1:0] dir,
  input  logic       wall_hit,
  input  logic       tank_hit,
  output logic [9:0] X_Bullet,
  output logic [9:0] Y_Bullet,
  output logic       bullet_on,
  output logic [1:0] hit,
  output logic       score
);

  typedef enum logic [1:0] {IDLE, FLY, DONE, COOL} state_t;

  state_t      state, state_n;
  logic        frame_q;
  logic        tick;
  logic [9:0]  x_n, y_n;
  logic [9:0]  x_move, y_move;
  logic [10:0] x_inc, y_inc;
  logic        at_edge;
  logic [1:0]  dir_q, dir_n;
  logic [7:0]  life_q, life_n;
  logic [7:0]  cool_q, cool_n;
  logic [1:0]  hit_q, hit_n;
`ifdef BULLET_BOUNCE_EN
  logic [1:0]  bounce_q, bounce_n;
`endif

  assign tick  = frame_clk & ~frame_q;
  assign x_inc = {1'b0, X_Bullet} + {1'b0, BULLET_STEP};
  assign y_inc = {1'b0, Y_Bullet} + {1'b0, BULLET_STEP};

  // Candidate next position and whether that step leaves the playfield
  always_comb begin
    x_move  = X_Bullet;
    y_move  = Y_Bullet;
    at_edge = 1'b0;
    unique case (dir_q)
      2'b00: begin
        at_edge = Y_Bullet < BULLET_STEP;
        y_move  = Y_Bullet - BULLET_STEP;
      end
      2'b01: begin
        at_edge = x_inc > {1'b0, X_MAX};
        x_move  = x_inc[9:0];
      end
      2'b10: begin
        at_edge = y_inc > {1'b0, Y_MAX};
        y_move  = y_inc[9:0];
      end
      default: begin
        at_edge = X_Bullet < BULLET_STEP;
        x_move  = X_Bullet - BULLET_STEP;
      end
    endcase
  end

  // Next-state, datapath updates and outputs
  always_comb begin
    state_n   = state;
    x_n       = X_Bullet;
    y_n       = Y_Bullet;
    dir_n     = dir_q;
    life_n    = life_q;
    cool_n    = cool_q;
    hit_n     = hit_q;
`ifdef BULLET_BOUNCE_EN
    bounce_n  = bounce_q;
`endif
    bullet_on = 1'b0;
    hit       = 2'b00;
    score     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire) begin
          state_n  = FLY;
          x_n      = X_Tank + (Tank_Width >> 1);
          y_n      = Y_Tank + (Tank_Height >> 1);
          dir_n    = dir;
          life_n   = 8'd0;
`ifdef BULLET_BOUNCE_EN
          bounce_n = 2'd0;
`endif
        end
      end
      FLY: begin
        bullet_on = 1'b1;
        if (tank_hit) begin
          state_n = DONE;
          hit_n   = 2'b01;
          score   = 1'b1;
        end else if (wall_hit) begin
`ifdef BULLET_BOUNCE_EN
          if (bounce_q != 2'd3) begin
            dir_n    = dir_q ^ 2'b10;
            bounce_n = bounce_q + 2'd1;
          end else begin
            state_n = DONE;
            hit_n   = 2'b10;
          end
`else
          state_n = DONE;
          hit_n   = 2'b10;
`endif
        end else if (tick && at_edge) begin
          state_n = DONE;
          hit_n   = 2'b10;
        end else if (life_q == BULLET_LIFE) begin
          state_n = DONE;
          hit_n   = 2'b10;
        end else if (tick) begin
          x_n    = x_move;
          y_n    = y_move;
          life_n = life_q + 8'd1;
        end
      end
      DONE: begin
        hit     = hit_q;
        state_n = COOL;
        cool_n  = 8'd0;
      end
      COOL: begin
        if (cool_q == COOLDOWN) begin
          state_n = IDLE;
        end else if (tick) begin
          cool_n = cool_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      frame_q  <= 1'b0;
      X_Bullet <= 10'd0;
      Y_Bullet <= 10'd0;
      dir_q    <= 2'b00;
      life_q   <= 8'd0;
      cool_q   <= 8'd0;
      hit_q    <= 2'b00;
`ifdef BULLET_BOUNCE_EN
      bounce_q <= 2'd0;
`endif
    end else begin
      state    <= state_n;
      frame_q  <= frame_clk;
      X_Bullet <= x_n;
      Y_Bullet <= y_n;
      dir_q    <= dir_n;
      life_q   <= life_n;
      cool_q   <= cool_n;
      hit_q    <= hit_n;
`ifdef BULLET_BOUNCE_EN
      bounce_q <= bounce_n;
`endif
    end
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller against a frame-level model.
// Define BULLET_BOUNCE_EN on both files to exercise the ricochet option.
module tb_bullet_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] X_Tank = 10'd0;
  logic [9:0] Y_Tank = 10'd0;
  logic [9:0] Tank_Width = 10'd0;
  logic [9:0] Tank_Height = 10'd0;
  logic [1:0] dir = 2'b00;
  logic       wall_hit = 1'b0;
  logic       tank_hit = 1'b0;
  logic [9:0] X_Bullet, Y_Bullet;
  logic       bullet_on;
  logic [1:0] hit;
  logic       score;

  int n_chk = 0;
  int n_fail = 0;

  bullet_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
    .X_Tank(X_Tank), .Y_Tank(Y_Tank),
    .Tank_Width(Tank_Width), .Tank_Height(Tank_Height),
    .dir(dir), .wall_hit(wall_hit), .tank_hit(tank_hit),
    .X_Bullet(X_Bullet), .Y_Bullet(Y_Bullet),
    .bullet_on(bullet_on), .hit(hit), .score(score)
  );

  always #5 Clk = ~Clk;

  // Model: phase 0 idle, 1 flying, 2 just retired, 3 cooling down
  int m_ph, m_x, m_y, m_dir, m_life, m_cool, m_hit, m_bnc;
  bit m_fprev;

  function automatic int exp_on();
    return (m_ph == 1) ? 1 : 0;
  endfunction

  function automatic int exp_hit();
    return (m_ph == 2) ? m_hit : 0;
  endfunction

  function automatic int exp_score();
    return (m_ph == 1 && tank_hit) ? 1 : 0;
  endfunction

  task automatic model_step();
    bit tk;
    int nx, ny;
    tk = frame_clk && !m_fprev;
    if (Reset) begin
      m_ph = 0; m_x = 0; m_y = 0; m_dir = 0; m_life = 0;
      m_cool = 0; m_hit = 0; m_bnc = 0; m_fprev = 0;
      return;
    end
    m_fprev = frame_clk;
    case (m_ph)
      0: if (fire) begin
        m_ph = 1;
        m_x = (X_Tank + Tank_Width / 2) % 1024;
        m_y = (Y_Tank + Tank_Height / 2) % 1024;
        m_dir = dir; m_life = 0; m_bnc = 0;
      end
      1: begin
        nx = m_x; ny = m_y;
        if (m_dir == 0) ny = m_y - 4;
        else if (m_dir == 1) nx = m_x + 4;
        else if (m_dir == 2) ny = m_y + 4;
        else nx = m_x - 4;
        if (tank_hit) begin
          m_ph = 2; m_hit = 1;
        end else if (wall_hit) begin
`ifdef BULLET_BOUNCE_EN
          if (m_bnc < 3) begin
            m_dir = m_dir ^ 2; m_bnc++;
          end else begin
            m_ph = 2; m_hit = 2;
          end
`else
          m_ph = 2; m_hit = 2;
`endif
        end else if (tk && (nx < 0 || nx > 639 || ny < 0 || ny > 479)) begin
          m_ph = 2; m_hit = 2;
        end else if (m_life == 120) begin
          m_ph = 2; m_hit = 2;
        end else if (tk) begin
          m_x = nx; m_y = ny; m_life++;
        end
      end
      2: begin m_ph = 3; m_cool = 0; end
      default: if (m_cool == 15) m_ph = 0; else if (tk) m_cool++;
    endcase
  endtask

  task automatic cyc();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ftick();
    frame_clk = 1'b1; cyc();
    frame_clk = 1'b0; cyc();
  endtask

  task automatic spawn(input int tx, input int ty, input int d);
    X_Tank = 10'(tx); Y_Tank = 10'(ty);
    Tank_Width = 10'd32; Tank_Height = 10'd32;
    dir = 2'(d); fire = 1'b1; cyc(); fire = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; fire = 1'b1; cyc(); cyc();
    fire = 1'b0; Reset = 1'b0;
    n_chk++;
    if (X_Bullet !== 10'd0 || Y_Bullet !== 10'd0 || bullet_on !== 1'b0 ||
        hit !== 2'b00 || score !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: x=%0d y=%0d on=%b hit=%b score=%b, need all 0",
               X_Bullet, Y_Bullet, bullet_on, hit, score);
    end
  endtask

  task automatic test_fire_move();
    spawn(100, 200, 1);
    n_chk++;
    if (X_Bullet !== 10'd116 || Y_Bullet !== 10'd216 || bullet_on !== 1'b1) begin
      n_fail++;
      $display("FAIL spawn: x=%0d y=%0d on=%b, need 116 216 1",
               X_Bullet, Y_Bullet, bullet_on);
    end
    X_Tank = 10'd300; dir = 2'b10;
    repeat (3) ftick();
    n_chk++;
    if (X_Bullet !== 10'd128 || Y_Bullet !== 10'd216 || bullet_on !== 1'b1) begin
      n_fail++;
      $display("FAIL move3: x=%0d y=%0d on=%b, need 128 216 1",
               X_Bullet, Y_Bullet, bullet_on);
    end
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask

  task automatic test_edge_cool();
    spawn(621, 100, 1);
    frame_clk = 1'b1; cyc();
    n_chk++;
    if (X_Bullet !== 10'd637 || hit !== 2'b10 || bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL edge: x=%0d hit=%b on=%b, need 637 10 0",
               X_Bullet, hit, bullet_on);
    end
    frame_clk = 1'b0; cyc();
    n_chk++;
    if (hit !== 2'b00) begin
      n_fail++;
      $display("FAIL edge_hold: hit=%b, need 00", hit);
    end
    repeat (14) ftick();
    fire = 1'b1;
    ftick();
    n_chk++;
    if (bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL cool_fire: on=%b, need 0", bullet_on);
    end
    cyc(); fire = 1'b0;
    n_chk++;
    if (bullet_on !== 1'b1) begin
      n_fail++;
      $display("FAIL refire: on=%b, need 1", bullet_on);
    end
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask

  task automatic test_priority();
    spawn(100, 100, 0);
    tank_hit = 1'b1; wall_hit = 1'b1; frame_clk = 1'b1;
    #1;
    n_chk++;
    if (score !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_score: score=%b, need 1", score);
    end
    cyc();
    tank_hit = 1'b0; wall_hit = 1'b0; frame_clk = 1'b0;
    #1;
    n_chk++;
    if (hit !== 2'b01 || score !== 1'b0 || bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_hit: hit=%b score=%b on=%b, need 01 0 0",
               hit, score, bullet_on);
    end
    cyc();
    n_chk++;
    if (hit !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_done1: hit=%b, need 00", hit);
    end
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask

  task automatic test_fire_hold();
    int ticks_on;
    fire = 1'b1;
    spawn(100, 200, 3);
    fire = 1'b1;
    X_Tank = 10'd400;
    repeat (2) ftick();
    n_chk++;
    if (X_Bullet !== 10'd108 || bullet_on !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_fly: x=%0d on=%b, need 108 1", X_Bullet, bullet_on);
    end
    tank_hit = 1'b1; cyc(); tank_hit = 1'b0;
    cyc();
    ticks_on = 0;
    for (int i = 0; i < 15; i++) begin
      ftick();
      if (bullet_on) ticks_on++;
    end
    n_chk++;
    if (ticks_on != 0) begin
      n_fail++;
      $display("FAIL hold_cool: live in %0d cool ticks, need 0", ticks_on);
    end
    cyc(); cyc();
    n_chk++;
    if (bullet_on !== 1'b1 || X_Bullet !== 10'd416) begin
      n_fail++;
      $display("FAIL hold_refire: on=%b x=%0d, need 1 416", bullet_on, X_Bullet);
    end
    fire = 1'b0;
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask

  task automatic test_reset_flight();
    spawn(100, 200, 1);
    ftick();
    Reset = 1'b1; tank_hit = 1'b1; cyc();
    Reset = 1'b0; tank_hit = 1'b0;
    n_chk++;
    if (X_Bullet !== 10'd0 || Y_Bullet !== 10'd0 || bullet_on !== 1'b0 ||
        hit !== 2'b00 || score !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fly: x=%0d y=%0d on=%b hit=%b score=%b, need 0",
               X_Bullet, Y_Bullet, bullet_on, hit, score);
    end
    spawn(100, 200, 1);
    n_chk++;
    if (bullet_on !== 1'b1 || X_Bullet !== 10'd116) begin
      n_fail++;
      $display("FAIL rst_spawn: on=%b x=%0d, need 1 116", bullet_on, X_Bullet);
    end
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask

  task automatic test_expiry();
    spawn(600, 100, 3);
    repeat (119) ftick();
    n_chk++;
    if (bullet_on !== 1'b1 || X_Bullet !== 10'd140) begin
      n_fail++;
      $display("FAIL exp_119: on=%b x=%0d, need 1 140", bullet_on, X_Bullet);
    end
    ftick();
    n_chk++;
    if (hit !== 2'b10 || bullet_on !== 1'b0 || X_Bullet !== 10'd136) begin
      n_fail++;
      $display("FAIL expiry: hit=%b on=%b x=%0d, need 10 0 136",
               hit, bullet_on, X_Bullet);
    end
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask

`ifdef BULLET_BOUNCE_EN
  task automatic test_bounce();
    int want_y [4] = '{220, 216, 220, 216};
    spawn(100, 200, 0);
    for (int i = 0; i < 3; i++) begin
      wall_hit = 1'b1; cyc(); wall_hit = 1'b0;
      ftick();
      n_chk++;
      if (bullet_on !== 1'b1 || Y_Bullet !== 10'(want_y[i])) begin
        n_fail++;
        $display("FAIL bounce%0d: on=%b y=%0d, need 1 %0d",
                 i, bullet_on, Y_Bullet, want_y[i]);
      end
    end
    wall_hit = 1'b1; cyc(); wall_hit = 1'b0;
    n_chk++;
    if (hit !== 2'b10 || bullet_on !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce4: hit=%b on=%b, need 10 0", hit, bullet_on);
    end
    Reset = 1'b1; cyc(); Reset = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      Reset     = ($urandom_range(0, 299) == 0);
      fire      = ($urandom_range(0, 2) == 0);
      frame_clk = ($urandom_range(0, 3) == 0) ? ~frame_clk : frame_clk;
      tank_hit  = ($urandom_range(0, 59) == 0);
      wall_hit  = ($urandom_range(0, 59) == 0);
      dir       = 2'($urandom_range(0, 3));
      X_Tank    = 10'($urandom_range(0, 600));
      Y_Tank    = 10'($urandom_range(0, 440));
      Tank_Width  = 10'($urandom_range(0, 32));
      Tank_Height = 10'($urandom_range(0, 32));
      #1;
      n_chk++;
      if (score !== 1'(exp_score())) begin
        n_fail++;
        $display("FAIL rnd_score @%0d: got %b need %0d", i, score, exp_score());
      end
      cyc();
      n_chk++;
      if (bullet_on !== 1'(exp_on()) || hit !== 2'(exp_hit())) begin
        n_fail++;
        $display("FAIL rnd_state @%0d: on=%b hit=%b need %0d %0d",
                 i, bullet_on, hit, exp_on(), exp_hit());
      end
      n_chk++;
      if (X_Bullet !== 10'(m_x) || Y_Bullet !== 10'(m_y)) begin
        n_fail++;
        $display("FAIL rnd_pos @%0d: x=%0d y=%0d need %0d %0d",
                 i, X_Bullet, Y_Bullet, m_x, m_y);
      end
    end
    Reset = 1'b1; fire = 1'b0; tank_hit = 1'b0; wall_hit = 1'b0;
    frame_clk = 1'b0; cyc(); Reset = 1'b0;
  endtask

  initial begin
    m_ph = 0; m_x = 0; m_y = 0; m_dir = 0; m_life = 0;
    m_cool = 0; m_hit = 0; m_bnc = 0; m_fprev = 0;
    test_reset();
    test_fire_move();
    test_edge_cool();
    test_priority();
    test_fire_hold();
    test_reset_flight();
    test_expiry();
`ifdef BULLET_BOUNCE_EN
    test_bounce();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
